// File: rtl/keccak_feeder_pkg.sv
// Shared types for the keccak message feeder: FSM encoding, widths and
// the packed-word bundle handed from the byte packer to the top.
package keccak_feeder_pkg;

    localparam int KF_WORD_W   = 64;
    localparam int KF_DIGEST_W = 512;
    localparam int KF_CNT_W    = 3;

    typedef logic [KF_CNT_W-1:0] kf_cnt_t;

    typedef enum logic [2:0] {
        KF_FILL        = 3'd0,
        KF_SEND        = 3'd1,
        KF_SEND_EMPTY  = 3'd2,
        KF_WAIT_DIGEST = 3'd3,
        KF_HOLD_DIGEST = 3'd4,
        KF_CORE_RST    = 3'd5
    } kf_state_e;

    typedef struct packed {
        logic [KF_WORD_W-1:0] pack;
        kf_cnt_t              num;
        logic                 last_f;
        logic                 full;
    } kf_word_t;

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs accepted bytes MSB-first into a 64-bit word and records the
// tail length of the final word of a message.
module keccak_byte_packer
    import keccak_feeder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       acc_i,
    input  logic [7:0] data_i,
    input  logic       last_i,
    output kf_word_t   word_o,
    output kf_cnt_t    cnt_o,
    output logic       word_done_o
);

    logic [KF_WORD_W-1:0] pack_q;
    logic [KF_WORD_W-1:0] pack_d;
    kf_cnt_t              cnt_q;
    kf_cnt_t              num_q;
    logic                 last_f_q;
    logic                 full_q;

    assign word_done_o = acc_i & ((cnt_q == 3'd7) | last_i);

    // byte c lands at bits [63-8c -: 8], i.e. offset (7-c)*8 = {~c,000}
    always_comb begin
        pack_d = pack_q;
        pack_d[{~cnt_q, 3'b000} +: 8] = data_i;
    end

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            pack_q   <= '0;
            cnt_q    <= '0;
            num_q    <= '0;
            last_f_q <= 1'b0;
            full_q   <= 1'b0;
        end else if (acc_i) begin
            pack_q <= pack_d;
            cnt_q  <= cnt_q + 1'b1;
            if (word_done_o) begin
                last_f_q <= last_i & (cnt_q != 3'd7);
                num_q    <= cnt_q + 1'b1;
                full_q   <= last_i & (cnt_q == 3'd7);
            end
        end
    end

    assign word_o.pack   = pack_q;
    assign word_o.num    = num_q;
    assign word_o.last_f = last_f_q;
    assign word_o.full   = full_q;
    assign cnt_o         = cnt_q;

endmodule

// File: rtl/keccak_msg_feeder.sv
// Byte-stream front end for the keccak core. Optional digest watchdog is
// enabled by defining KECCAK_FEEDER_WATCHDOG_EN.
module keccak_msg_feeder
    import keccak_feeder_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [KF_WORD_W-1:0]   k_in,
    output logic                   k_in_ready,
    output logic                   k_is_last,
    output logic [2:0]             k_byte_num,
    input  logic                   k_buffer_full,
    input  logic [KF_DIGEST_W-1:0] k_out,
    input  logic                   k_out_ready,
    output logic                   k_reset,
    output logic [KF_DIGEST_W-1:0] d_data,
    output logic                   d_valid,
    input  logic                   d_ready,
    output logic                   busy,
    output logic                   error
);

    kf_state_e              state_q;
    logic [KF_DIGEST_W-1:0] d_data_q;
    logic                   d_valid_q;

    kf_word_t word;
    kf_cnt_t  cnt;
    logic     word_done;
    logic     acc;
    logic     in_send;
    logic     in_empty;
    logic     xfer;
    logic     clr;

    assign s_ready  = (state_q == KF_FILL) & ~reset;
    assign acc      = s_valid & s_ready;
    assign in_send  = (state_q == KF_SEND);
    assign in_empty = (state_q == KF_SEND_EMPTY);
    assign xfer     = (in_send | in_empty) & ~k_buffer_full;
    // pack is cleared whenever FILL is re-entered
    assign clr      = (in_send & xfer & ~word.last_f & ~word.full)
                    | (state_q == KF_CORE_RST);

    keccak_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (clr),
        .acc_i       (acc),
        .data_i      (s_data),
        .last_i      (s_last),
        .word_o      (word),
        .cnt_o       (cnt),
        .word_done_o (word_done)
    );

`ifdef KECCAK_FEEDER_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;
`else
    logic wd_param_unused;
    assign wd_param_unused = |WATCHDOG_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= KF_FILL;
            d_data_q  <= '0;
            d_valid_q <= 1'b0;
`ifdef KECCAK_FEEDER_WATCHDOG_EN
            wd_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef KECCAK_FEEDER_WATCHDOG_EN
            wd_q <= '0;
`endif
            unique case (state_q)
                KF_FILL: begin
                    if (word_done) state_q <= KF_SEND;
                end
                KF_SEND: begin
                    if (!k_buffer_full) begin
                        if (word.last_f)    state_q <= KF_WAIT_DIGEST;
                        else if (word.full) state_q <= KF_SEND_EMPTY;
                        else                state_q <= KF_FILL;
                    end
                end
                KF_SEND_EMPTY: begin
                    if (!k_buffer_full) state_q <= KF_WAIT_DIGEST;
                end
                KF_WAIT_DIGEST: begin
                    if (k_out_ready) begin
                        d_data_q  <= k_out;
                        d_valid_q <= 1'b1;
                        state_q   <= KF_HOLD_DIGEST;
                    end
`ifdef KECCAK_FEEDER_WATCHDOG_EN
                    else if (wd_q == WD_W'(WATCHDOG_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= KF_CORE_RST;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                KF_HOLD_DIGEST: begin
                    if (d_ready) begin
                        d_valid_q <= 1'b0;
                        state_q   <= KF_CORE_RST;
                    end
                end
                KF_CORE_RST: begin
                    state_q <= KF_FILL;
                end
                default: begin
                    state_q <= KF_FILL;
                end
            endcase
        end
    end

    assign k_in_ready = in_send | in_empty;
    assign k_in       = in_send ? word.pack : '0;
    assign k_is_last  = (in_send & word.last_f) | in_empty;
    assign k_byte_num = (in_send & word.last_f) ? word.num : 3'd0;
    assign k_reset    = reset | (state_q == KF_CORE_RST);
    assign busy       = ~((state_q == KF_FILL) & (cnt == 3'd0));
    assign d_data     = d_data_q;
    assign d_valid    = d_valid_q;

`ifdef KECCAK_FEEDER_WATCHDOG_EN
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: doc/keccak_msg_feeder.md
# keccak_msg_feeder

Byte-stream front end for the `keccak` hash core. It accepts message bytes over a valid/ready stream and packs them MSB-first into 64-bit words. It drives the core's `in`/`in_ready`/`is_last`/`byte_num` input interface under `buffer_full` backpressure, then captures the 512-bit digest and presents it on a valid/ready output. Once the digest has been taken, it re-arms the core with a one-cycle core reset so the next message can start.

## Interface
- `WATCHDOG_CYCLES`, 64, maximum number of cycles in WAIT_DIGEST before an error is flagged. Used only when `KECCAK_FEEDER_WATCHDOG_EN` is defined.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `s_data`  in  8  message byte.
- `s_valid`  in  1  byte valid.
- `s_last`  in  1  final byte of the message; qualified by `s_valid`.
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`.
- `k_in`  out  64  word to the core; first byte is in `[63:56]`.
- `k_in_ready`  out  1  word valid to the core.
- `k_is_last`  out  1  final word flag.
- `k_byte_num`  out  3  number of valid bytes in the final word (0–7).
- `k_buffer_full`  in  1  core backpressure.
- `k_out`  in  512  core digest.
- `k_out_ready`  in  1  core digest valid (sticky until core reset).
- `k_reset`  out  1  core reset; `reset | rst_pulse`.
- `d_data`  out  512  registered digest.
- `d_valid`  out  1  digest valid.
- `d_ready`  in  1  digest consumer ready.
- `busy`  out  1  high in every state except FILL with 0 bytes packed.
- `error`  out  1  watchdog error, sticky until `reset`; tied to 0 when the macro is absent.

## Operation
- States:
  - FILL: `s_ready`=1.
  - SEND: present the packed word.
  - SEND_EMPTY: present a zero-byte last word.
  - WAIT_DIGEST.
  - HOLD_DIGEST.
  - CORE_RST.
- FILL:
  - The accepted byte at count `c` (0–7) is written to `pack[63-8c -: 8]`; `c` then increments.
  - Unwritten bytes are 0; `pack` is cleared on entry to FILL.
  - 8th byte without `s_last` → SEND, with `last_f`=0.
  - Byte with `s_last` at total `n`<8 → SEND, with `last_f`=1 and `num`=`n`.
  - Byte with `s_last` at total `n`=8 → SEND with `last_f`=0, then SEND_EMPTY.
- SEND / SEND_EMPTY:
  - `k_in_ready`=1; `k_in`=`pack` (all zeros in SEND_EMPTY).
  - `k_is_last`=`k_in_ready & last_f`; `k_byte_num`=`num` when last, else 0.
  - Transfer occurs on a cycle with `k_buffer_full`=0. Outputs are held stable otherwise.
  - After transfer: the last word → WAIT_DIGEST; the full word of an 8-byte tail → SEND_EMPTY; otherwise → FILL.
  - `k_is_last` is never 1 while `k_in_ready`=0.
- WAIT_DIGEST: on `k_out_ready`=1, `d_data`←`k_out` and `d_valid`←1 → HOLD_DIGEST.
- HOLD_DIGEST: `d_data`/`d_valid` are held until `d_valid & d_ready` → CORE_RST.
- CORE_RST: `rst_pulse`=1 for exactly one cycle; `d_valid`←0 → FILL.
- Zero-length messages are not representable on the byte stream and are not supported.

## Timing
- Reset values:
  - `s_ready`=0 while `reset` is high, then 1 on the first cycle after.
  - `k_in`=0, `k_in_ready`=0, `k_is_last`=0, `k_byte_num`=0.
  - `k_reset`=1 while `reset` is high.
  - `d_data`=0, `d_valid`=0, `busy`=0, `error`=0.
  - State is FILL with `c`=0.
- Word presentation: `k_in_ready` rises the cycle after the byte that completes the word is accepted.
- Throughput: 9 cycles per full word when unstalled.
- Digest: `d_valid` rises the cycle after `k_out_ready` is first sampled high in WAIT_DIGEST.
- `k_reset` pulse: the cycle after the `d` handshake. FILL (`s_ready`=1) follows one cycle later.
- `s_ready` is 0 in every state except FILL, so bytes offered during SEND are not consumed.
- `reset` mid-operation: the packed bytes and digest are discarded, `k_reset` is asserted, and the block returns to the reset values.

## Configuration
- `KECCAK_FEEDER_WATCHDOG_EN` defined:
  - A counter clears on entry to WAIT_DIGEST.
  - If it reaches `WATCHDOG_CYCLES` without `k_out_ready`, `error`←1 and the block goes to CORE_RST, then FILL.
  - `d_valid` is not raised for that message.
- Undefined: no counter; `error`=0 constantly; WAIT_DIGEST waits indefinitely.

## Structure
- `keccak_feeder_pkg`:
  - state encoding (6 states, 3 bits);
  - `KF_WORD_W`=64, `KF_DIGEST_W`=512;
  - byte-count width = 3 bits, plus a full flag.
- Sub-module `keccak_byte_packer`:
  - byte-to-word packing, count and tail-length logic;
  - outputs `pack`, `num`, `last_f`, `word_done`.
- The FSM, core handshake and digest register live in the top module.

## Test plan
- Bytes 61 62 63, `s_last` on the 3rd:
  - single word `k_in`=64'h6162630000000000, `k_is_last`=1, `k_byte_num`=3;
  - `d_data`==`k_out`;
  - one-cycle `k_reset` after the `d` handshake.
- 8 bytes 01–08 with `s_last` on the 8th:
  - word 64'h0102030405060708 with `k_is_last`=0;
  - then a zero word with `k_is_last`=1, `k_byte_num`=0.
- `k_buffer_full`=1 for 5 cycles while in SEND: `k_in`, `k_is_last` and `k_byte_num` stay stable, `s_ready`=0, and the transfer happens on the first cycle with `k_buffer_full`=0.
- 17-byte message: 3 words, with the final word `k_byte_num`=1 and its byte in `[63:56]`.
- `d_ready`=0 for 10 cycles: `d_valid`=1 and `d_data` stay stable with no `k_reset`; the pulse comes the cycle after `d_ready` rises.
- Watchdog build, `k_out_ready` held at 0:
  - `error`=1 after 64 cycles in WAIT_DIGEST, followed by a `k_reset` pulse;
  - a later `reset` clears `error`;
  - `reset` after 5 bytes of the next message returns `s_ready`=1 with `c`=0.
